// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier with valid/ready on both sides.
// Each BUSY cycle retires RADIX_BITS bits of the multiplier, so a result takes
// ITER = WIDTH/RADIX_BITS compute cycles. Signed mode multiplies magnitudes
// and negates the final sum when the operand signs differ.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   operand beat handshake (a, b, signed_mode)
//   out_valid / out_ready product handshake (product, 2*WIDTH bits)
//   busy                  high while an operation is in flight or unclaimed
module seq_multiplier #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);
  localparam int ITER = WIDTH / RADIX_BITS;
  localparam int PW   = 2 * WIDTH;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  // a_sh carries a_mag << (cnt*RADIX_BITS); b_sh carries the not-yet-retired
  // multiplier bits in its low end. Shifting both avoids a variable part-select.
  logic [PW-1:0]                  a_sh;
  logic [WIDTH-1:0]               b_sh;
  logic                           neg;
  logic [PW-1:0]                  acc;
  logic [CW-1:0]                  cnt;
  logic [WIDTH-1:0]               a_abs, b_abs;
  logic [RADIX_BITS-1:0][PW-1:0]  pp;
  logic [PW-1:0]                  step, acc_nxt;
  logic                           last;

  // Magnitudes: -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct
  // unsigned magnitude, so no extra bit is needed.
  assign a_abs = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign b_abs = (signed_mode && b[WIDTH-1]) ? -b : b;
  assign last  = (cnt == LAST);

  // Partial products for this digit: one gated, shifted copy of a per bit.
  for (genvar i = 0; i < RADIX_BITS; i++) begin : g_pp
    assign pp[i] = b_sh[i] ? (a_sh << i) : '0;
  end

  always_comb begin
    step = '0;
    for (int i = 0; i < RADIX_BITS; i++) step = step + pp[i];
  end

  assign acc_nxt = acc + step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_sh <= PW'(a_abs);
          b_sh <= b_abs;
          neg  <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc  <= '0;
          cnt  <= '0;
        end
        BUSY: begin
          acc  <= acc_nxt;
          a_sh <= a_sh << RADIX_BITS;
          b_sh <= b_sh >> RADIX_BITS;
          // Counter parks at ITER-1; it only restarts on the next capture.
          if (last) product <= neg ? -acc_nxt : acc_nxt;
          else      cnt     <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;
  localparam int W    = 32;
  localparam int R    = 4;
  localparam int ITER = W / R;
  localparam int PW   = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
  logic [W-1:0]  a, b;
  logic [PW-1:0] product;

  logic          rand_rdy = 1'b0;
  logic          rdy_m    = 1'b1;
  logic          rdy_r    = 1'b1;
  assign out_ready = rand_rdy ? rdy_r : rdy_m;

  int            checks   = 0;
  int            failures = 0;
  longint        cyc      = 0;
  logic [PW-1:0] exp_q[$];
  longint        t0_q[$];

  seq_multiplier #(.WIDTH(W), .RADIX_BITS(R)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: extend both operands to full product width (sign- or zero-)
  // and take the product modulo 2^(2W).
  function automatic logic [PW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic sm);
    logic [PW-1:0] xe, ye;
    xe = sm ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
    ye = sm ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
    return xe * ye;
  endfunction

  function automatic logic [W-1:0] rv();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = W'(1);
      4:       v = {1'b0, {(W-1){1'b1}}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // Called just after a falling edge; returns just after the falling edge
  // that follows the accepting rising edge. t0 = index of the accept edge.
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm,
                    input logic [PW-1:0] e, output longint t0);
    int n;
    n = 0;
    a = x; b = y; signed_mode = sm; in_valid = 1'b1;
    while (!in_ready) begin
      if (n > 100) begin
        chk("accept_timeout", PW'(0), PW'(1));
        in_valid = 1'b0;
        t0 = -1;
        return;
      end
      n++;
      @(negedge clk);
    end
    t0 = cyc + 1;
    exp_q.push_back(e);
    t0_q.push_back(t0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", PW'(exp_q.size()), PW'(0));
      exp_q.delete();
      t0_q.delete();
    end
  endtask

  // Random consumer backpressure.
  initial forever begin
    @(negedge clk);
    rdy_r = 1'(($urandom_range(0, 3)) != 0);
  end

  // Monitor: samples just after each falling edge, so the values seen are the
  // ones the next rising edge will act on.
  initial begin
    logic          prev_ov, prev_or;
    logic [PW-1:0] prev_prod;
    prev_ov = 1'b0; prev_or = 1'b0; prev_prod = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n !== 1'b1) begin
        prev_ov = 1'b0;
        continue;
      end
      chk("busy_vs_in_ready", PW'(busy), PW'(!in_ready));
      if (prev_ov && !prev_or) begin
        chk("hold_valid", PW'(out_valid), PW'(1));
        chk("hold_product", product, prev_prod);
      end
      if (out_valid) chk("in_ready_low_in_done", PW'(in_ready), PW'(0));
      if (out_valid && !prev_ov) begin
        if (t0_q.size() == 0) chk("spurious_valid", PW'(1), PW'(0));
        else                  chk("latency", PW'(cyc - t0_q.pop_front()), PW'(ITER));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", PW'(1), PW'(0));
        else                   chk("product", product, exp_q.pop_front());
      end
      prev_ov = out_valid; prev_or = out_ready; prev_prod = product;
    end
  end

  typedef struct {
    logic [W-1:0]  x, y;
    logic          sm;
    logic [PW-1:0] e;
  } vec_t;

  initial begin
    vec_t   dv[$];
    longint t, t_prev;
    int     n;
    logic [W-1:0] x, y;
    logic sm;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  PW'(in_ready),  PW'(1));
    chk("rst_out_valid", PW'(out_valid), PW'(0));
    chk("rst_busy",      PW'(busy),      PW'(0));
    chk("rst_product",   product,        PW'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, issued back to back with out_ready high.
    dv.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001});
    dv.push_back('{32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB});
    dv.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000});
    dv.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000});
    dv.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000});
    dv.push_back('{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0});
    dv.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h1});
    rdy_m = 1'b1;
    t_prev = -1;
    foreach (dv[i]) begin
      op(dv[i].x, dv[i].y, dv[i].sm, dv[i].e, t);
      // Accept edge, ITER compute edges, one output-handshake edge back to
      // IDLE, then the next accept edge.
      if (i > 0) chk("accept_spacing", PW'(t - t_prev), PW'(ITER + 2));
      t_prev = t;
    end
    drain();

    // Backpressure: result held, second beat pending and refused meanwhile.
    rdy_m = 1'b0;
    op(32'd1000, 32'd3000, 1'b0, 64'd3000000, t);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_out_valid", PW'(out_valid), PW'(1));
    a = 32'hFFFF_FFF0; b = 32'd100; signed_mode = 1'b1; in_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("bp_in_ready", PW'(in_ready), PW'(0));
    end
    rdy_m = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", PW'(in_ready), PW'(1));
    op(32'hFFFF_FFF0, 32'd100, 1'b1, 64'hFFFF_FFFF_FFFF_F9C0, t);
    drain();

    // Reset in the middle of an operation.
    op(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, model(32'hDEAD_BEEF, 32'h1234_5678, 1'b0), t);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", PW'(out_valid), PW'(0));
    chk("midrst_product",   product,        PW'(0));
    chk("midrst_in_ready",  PW'(in_ready),  PW'(1));
    chk("midrst_busy",      PW'(busy),      PW'(0));
    exp_q.delete();
    t0_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op(32'd12345, 32'd6789, 1'b0, 64'd83810205, t);
    drain();

    // Random operands, both modes, random consumer stalls and idle gaps.
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      x = rv(); y = rv(); sm = 1'($urandom_range(0, 1));
      op(x, y, sm, model(x, y, sm), t);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_rdy = 1'b0;
    rdy_m = 1'b1;
    drain();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
